// File: rtl/microwave.sv
// Microwave oven controller: three-digit BCD timer, keypad entry, cook/pause FSM, 7-seg display.
// Define MICROWAVE_KEY_IN_PAUSE_EN to also accept keypad entry while PAUSED (default: IDLE only).
module microwave #(
   parameter int unsigned TICKS_PER_SEC = 100
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   input  logic [9:0] keypad,
   output logic [6:0] sec_ones_segs,
   output logic [6:0] sec_tens_segs,
   output logic [6:0] mins_segs,
   output logic       mag_on
);

   localparam int unsigned PresW = $clog2(TICKS_PER_SEC);
   localparam logic [PresW-1:0] PresMax = PresW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {StIdle, StCook, StPaused} state_e;

   state_e           state_q, state_d;
   logic [3:0]       mins_q, mins_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic [PresW-1:0] presc_q, presc_d;
   logic [9:0]       key_hist_q;
   logic             mag_on_q;

   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_en;
   logic       time_zero;
   logic       start_ok;
   logic       halt;
   logic       tick;
   logic [3:0] dec_mins, dec_tens, dec_ones;
   logic       dec_zero;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // A key counts only on the first cycle of a clean single-key press.
   always_comb begin
      key_valid = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0) &&
                  (key_hist_q == 10'd0);
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) key_digit = 4'(i);
      end
   end

`ifdef MICROWAVE_KEY_IN_PAUSE_EN
   assign key_en = (state_q == StIdle) || (state_q == StPaused);
`else
   assign key_en = (state_q == StIdle);
`endif

   assign time_zero = ({mins_q, tens_q, ones_q} == 12'd0);
   assign start_ok  = !startn && door_closed && !time_zero;
   assign halt      = !door_closed || !stopn;
   assign tick      = (presc_q == PresMax);

   // One-second countdown with minute/ten-second borrows.
   always_comb begin
      dec_mins = mins_q;
      dec_tens = tens_q;
      dec_ones = ones_q;
      if (ones_q != 4'd0) begin
         dec_ones = ones_q - 4'd1;
      end else begin
         dec_ones = 4'd9;
         if (tens_q != 4'd0) begin
            dec_tens = tens_q - 4'd1;
         end else begin
            dec_tens = 4'd5;
            dec_mins = mins_q - 4'd1;
         end
      end
      dec_zero = ({dec_mins, dec_tens, dec_ones} == 12'd0);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!clearn) begin
         state_q    <= StIdle;
         mins_q     <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
         presc_q    <= '0;
         key_hist_q <= 10'd0;
         mag_on_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mins_q     <= mins_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         presc_q    <= presc_d;
         key_hist_q <= keypad;
         mag_on_q   <= (state_d == StCook);
      end
   end

   // Next-state and timer datapath.
   always_comb begin
      state_d = state_q;
      mins_d  = mins_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      presc_d = presc_q;
      unique case (state_q)
         StCook: begin
            if (halt) begin
               state_d = StPaused;
            end else if (tick) begin
               presc_d = '0;
               mins_d  = dec_mins;
               tens_d  = dec_tens;
               ones_d  = dec_ones;
               if (dec_zero) state_d = StIdle;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         StIdle, StPaused: begin
            if (!stopn) begin
               state_d = StIdle;
               mins_d  = 4'd0;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
            end else if (start_ok) begin
               state_d = StCook;
               presc_d = '0;
            end else if (key_en && key_valid) begin
               mins_d = tens_q;
               tens_d = ones_q;
               ones_d = key_digit;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      mag_on        = mag_on_q;
      mins_segs     = seg7(mins_q);
      sec_tens_segs = seg7(tens_q);
      sec_ones_segs = seg7(ones_q);
   end

endmodule

// File: tb/tb_microwave.sv
// Self-checking bench for microwave: directed scenarios plus randomized traffic
// against a digit-level behavioural model.
module tb_microwave;

   localparam int unsigned T = 5;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   localparam int M_IDLE = 0, M_COOK = 1, M_PAUSED = 2;
`ifdef MICROWAVE_KEY_IN_PAUSE_EN
   localparam bit KEY_IN_PAUSE = 1'b1;
`else
   localparam bit KEY_IN_PAUSE = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       clearn, startn, stopn, door_closed;
   logic [9:0] keypad;
   logic [6:0] sec_ones_segs, sec_tens_segs, mins_segs;
   logic       mag_on;

   microwave #(.TICKS_PER_SEC(T)) dut (
      .clock(clock), .clearn(clearn), .startn(startn), .stopn(stopn),
      .door_closed(door_closed), .keypad(keypad), .sec_ones_segs(sec_ones_segs),
      .sec_tens_segs(sec_tens_segs), .mins_segs(mins_segs), .mag_on(mag_on)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   int         m_state, m_min, m_ten, m_one, m_cnt;
   logic [9:0] m_prev;
   logic       m_mag;

   wire [27:0] dut_out = {mins_segs, sec_tens_segs, sec_ones_segs, mag_on};

   function automatic logic [27:0] exp_out();
      return {SEG_TAB[m_min], SEG_TAB[m_ten], SEG_TAB[m_one], m_mag};
   endfunction

   // Behavioural model, advanced once per rising edge from the inputs seen there.
   task automatic model_step();
      logic [9:0] prev;
      logic       key_ok;
      if (!clearn) begin
         m_state = M_IDLE; m_min = 0; m_ten = 0; m_one = 0; m_cnt = 0;
         m_prev = '0; m_mag = 1'b0;
         return;
      end
      prev   = m_prev;
      m_prev = keypad;
      key_ok = ($countones(keypad) == 1) && (prev == 10'd0);
      if (m_state == M_COOK) begin
         if (!door_closed || !stopn) begin
            m_state = M_PAUSED;
         end else if (m_cnt == T - 1) begin
            m_cnt = 0;
            if (m_one > 0) m_one--;
            else begin
               m_one = 9;
               if (m_ten > 0) m_ten--;
               else begin m_ten = 5; m_min--; end
            end
            if (m_min == 0 && m_ten == 0 && m_one == 0) m_state = M_IDLE;
         end else begin
            m_cnt++;
         end
      end else if (!stopn) begin
         m_state = M_IDLE; m_min = 0; m_ten = 0; m_one = 0;
      end else if (!startn && door_closed && (m_min + m_ten + m_one) != 0) begin
         m_state = M_COOK; m_cnt = 0;
      end else if (key_ok && (m_state == M_IDLE || (KEY_IN_PAUSE && m_state == M_PAUSED))) begin
         m_min = m_ten; m_ten = m_one;
         for (int i = 0; i < 10; i++) if (keypad[i]) m_one = i;
      end
      m_mag = (m_state == M_COOK);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      clearn = 1'b1; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; keypad = '0;
   endtask

   task automatic do_clear();
      clearn = 1'b0; tick(); clearn = 1'b1;
   endtask

   task automatic press(input int d);
      keypad = 10'(1) << d; tick();
      keypad = '0;          tick();
   endtask

   task automatic start_pulse();
      startn = 1'b0; tick(); startn = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      startn = 1'b0; keypad = 10'h004; clearn = 1'b0;
      tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL reset_state: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
      idle_inputs(); tick();
      checks++;
      if (dut_out !== exp_out()) begin
         errors++; $display("FAIL reset_model: got %h expected %h", dut_out, exp_out());
      end
   endtask

   task automatic test_key_entry();
      press(1); press(1); press(0);
      checks++;
      if (dut_out !== {7'h06, 7'h06, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL key_110: got %h expected %h", dut_out, {7'h06, 7'h06, 7'h3F, 1'b0});
      end
   endtask

   task automatic test_cook_tick();
      start_pulse();
      checks++;
      if (dut_out !== {7'h06, 7'h06, 7'h3F, 1'b1}) begin
         errors++; $display("FAIL cook_start: got %h expected %h", dut_out, {7'h06, 7'h06, 7'h3F, 1'b1});
      end
      repeat (T - 1) tick();
      checks++;
      if (dut_out !== {7'h06, 7'h06, 7'h3F, 1'b1}) begin
         errors++; $display("FAIL cook_pre_tick: got %h expected %h", dut_out, {7'h06, 7'h06, 7'h3F, 1'b1});
      end
      tick();
      checks++;
      if (dut_out !== {7'h06, 7'h3F, 7'h6F, 1'b1}) begin
         errors++; $display("FAIL cook_1_09: got %h expected %h", dut_out, {7'h06, 7'h3F, 7'h6F, 1'b1});
      end
   endtask

   task automatic test_borrow();
      do_clear(); press(1); press(0); press(0);
      start_pulse(); repeat (T) tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h6D, 7'h6F, 1'b1}) begin
         errors++; $display("FAIL borrow_0_59: got %h expected %h", dut_out, {7'h3F, 7'h6D, 7'h6F, 1'b1});
      end
   endtask

   task automatic test_pause();
      repeat (2) tick();
      door_closed = 1'b0; tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h6D, 7'h6F, 1'b0}) begin
         errors++; $display("FAIL pause_door: got %h expected %h", dut_out, {7'h3F, 7'h6D, 7'h6F, 1'b0});
      end
      repeat (3 * T) tick();
      door_closed = 1'b1; repeat (2 * T) tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h6D, 7'h6F, 1'b0}) begin
         errors++; $display("FAIL pause_frozen: got %h expected %h", dut_out, {7'h3F, 7'h6D, 7'h6F, 1'b0});
      end
      start_pulse(); repeat (T) tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h6D, 7'h7F, 1'b1}) begin
         errors++; $display("FAIL pause_resume: got %h expected %h", dut_out, {7'h3F, 7'h6D, 7'h7F, 1'b1});
      end
   endtask

   task automatic test_finish();
      do_clear(); press(2);
      start_pulse(); repeat (2 * T - 1) tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h06, 1'b1}) begin
         errors++; $display("FAIL finish_0_01: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h06, 1'b1});
      end
      tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL finish_0_00: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
      startn = 1'b0; repeat (3) tick(); startn = 1'b1;
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL start_at_zero: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
   endtask

   task automatic test_ignore();
      do_clear();
      keypad = 10'b0000000011; tick(); keypad = '0; tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL multi_key: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
      keypad = 10'(1) << 5; repeat (3) tick(); keypad = '0; tick();
      keypad = 10'(1) << 3; tick(); keypad = 10'(1) << 7; tick(); keypad = '0; tick();
      checks++;
      if (dut_out !== {7'h3F, 7'h6D, 7'h4F, 1'b0}) begin
         errors++; $display("FAIL held_key: got %h expected %h", dut_out, {7'h3F, 7'h6D, 7'h4F, 1'b0});
      end
      start_pulse(); repeat (2) tick();
      clearn = 1'b0; startn = 1'b0; keypad = 10'(1) << 4; tick();
      idle_inputs();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL clear_mid_cook: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
   endtask

   task automatic test_stop();
      logic [27:0] want;
      do_clear(); press(4);
      start_pulse(); tick(); press(9);
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h66, 1'b1}) begin
         errors++; $display("FAIL key_in_cook: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h66, 1'b1});
      end
      stopn = 1'b0; tick(); stopn = 1'b1; tick();
      press(8);
      want = KEY_IN_PAUSE ? {7'h3F, 7'h66, 7'h7F, 1'b0} : {7'h3F, 7'h3F, 7'h66, 1'b0};
      checks++;
      if (dut_out !== want) begin
         errors++; $display("FAIL key_in_pause: got %h expected %h", dut_out, want);
      end
      stopn = 1'b0; tick(); stopn = 1'b1; start_pulse();
      checks++;
      if (dut_out !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
         errors++; $display("FAIL stop_in_pause: got %h expected %h", dut_out, {7'h3F, 7'h3F, 7'h3F, 1'b0});
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_clear();
      for (int n = 0; n < 3000; n++) begin
         clearn      = ($urandom_range(0, 255) != 0);
         startn      = ($urandom_range(0, 7) != 0);
         stopn       = ($urandom_range(0, 31) != 0);
         door_closed = ($urandom_range(0, 15) != 0);
         keypad      = '0;
         if (startn && stopn && door_closed) begin
            case ($urandom_range(0, 19))
               0, 1, 2, 3, 4, 5: keypad = 10'(1) << $urandom_range(0, 9);
               6:                keypad = 10'($urandom);
               default:          keypad = '0;
            endcase
         end
         tick();
         checks++;
         if (dut_out !== exp_out()) begin
            errors++;
            if (bad < 10) $display("FAIL random_cycle_%0d: got %h expected %h", n, dut_out, exp_out());
            bad++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      m_state = M_IDLE; m_min = 0; m_ten = 0; m_one = 0; m_cnt = 0; m_prev = '0; m_mag = 1'b0;
      test_reset();
      test_key_entry();
      test_cook_tick();
      test_borrow();
      test_pause();
      test_finish();
      test_ignore();
      test_stop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave.md
MICROWAVE -- requirements
Module: microwave

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100, is the number of clock cycles per displayed second (minimum 2).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 clearn  input  1  reset and clear; synchronous, active-low.
REQ-004 startn  input  1  start request, active-low level.
REQ-005 stopn  input  1  stop/cancel request, active-low level.
REQ-006 door_closed  input  1  1 = door closed, 0 = door open.
REQ-007 keypad  input  10  one-hot digit keys; bit i = digit i.
REQ-008 sec_ones_segs  output  7  seven-segment code for seconds-ones digit.
REQ-009 sec_tens_segs  output  7  seven-segment code for seconds-tens digit.
REQ-010 mins_segs  output  7  seven-segment code for minutes digit.
REQ-011 mag_on  output  1  magnetron enable, registered, 1 only in COOK.

Function
REQ-012 State machine SHALL have exactly three states: IDLE, COOK and PAUSED.
REQ-013 Time SHALL be held as three BCD digits: mins, tens, ones.
REQ-014 Key accept: exactly one keypad bit high while the previous cycle's keypad was all-zero; any multi-bit or held pattern is ignored.
REQ-015 On an accepted key in an entry-enabled state: mins<=tens, tens<=ones, ones<=key digit, so entering 1,1,0 gives 1:10.
REQ-016 Priority per cycle: clearn, then door/stopn, then startn, then keypad.
REQ-017 IDLE/PAUSED -> COOK when startn=0, door_closed=1 and time != 0:00; mag_on=1 from the following cycle.
REQ-018 Entering COOK SHALL zero the prescaler.
REQ-019 In COOK, when the prescaler reaches TICKS_PER_SEC-1, it wraps to 0 and the time decrements by one second.
REQ-020 Decrement: ones 0 -> 9 with borrow to tens; tens 0 -> 5 with borrow to mins; tens entered above 5 decrement normally.
REQ-021 When the decrement yields 0:00, the FSM SHALL go to IDLE and mag_on SHALL be 0 next cycle; the display shows 0:00.
REQ-022 In COOK, door_closed=0 or stopn=0 SHALL cause COOK -> PAUSED, mag_on 0 next cycle, and freeze both time and prescaler.
REQ-023 PAUSED resumes only via REQ-017; closing the door alone does not resume.
REQ-024 stopn=0 in IDLE or PAUSED SHALL set the time to 0:00 and go to IDLE.
REQ-025 startn while in COOK, or with time 0:00 or door open, SHALL have no effect.
REQ-026 Keypad SHALL be ignored in COOK.
REQ-027 Segment encoding: bit0=a … bit6=g, active-high; codes 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
REQ-028 Segment outputs are combinational decodes of the registered digits.

Reset
REQ-029 clearn=0 at a rising edge SHALL set state IDLE, digits 0:00, prescaler 0, key-history 0 and mag_on 0.
REQ-030 After reset all three segment outputs SHALL show 7'h3F.
REQ-031 clearn SHALL take effect even mid-COOK and SHALL override all other inputs that cycle.

Configuration
REQ-032 Macro MICROWAVE_KEY_IN_PAUSE_EN defined: keypad entry SHALL be accepted in IDLE and in PAUSED.
REQ-033 MICROWAVE_KEY_IN_PAUSE_EN undefined: keypad entry SHALL be accepted in IDLE only.
REQ-034 The port list SHALL be identical in both builds.

Verification
REQ-035 Reset, then press keys 1,1,0 (each followed by all-zero) -> mins=06, tens=06, ones=3F, mag_on=0.
REQ-036 At 1:10, with door closed, pulse startn low -> mag_on=1 next cycle, and after TICKS_PER_SEC cycles the display is 1:09 (ones=6F).
REQ-037 Cooking at 1:00 -> after one tick the display is 0:59 (tens=6D, ones=6F).
REQ-038 Cooking, door_closed->0 -> mag_on=0 next cycle and the display is frozen; closing the door leaves mag_on=0; startn resumes from the frozen value.
REQ-039 Cook from 0:02 -> display 0:00 after 2*TICKS_PER_SEC cycles, with mag_on=0 the cycle after; startn then has no effect.
REQ-040 Keypad 10'b0000000011, or a held key, -> no digit shift; clearn low mid-cook -> 0:00, mag_on=0.
